// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller: digit count,
// blank pattern, active-low hex glyph table and prescaler width helper.
package seg7_pkg;

  localparam int DIGITS = 8;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segments ordered {g,f,e,d,c,b,a}, active-low, glyphs 0..F
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // A divider of 1 still needs a one-bit counter that simply stays at zero
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Bus between the value writer (master) and the scan controller (slave),
// carrying the load request, display value and the display pin outputs.
interface seg7_scan_ctrl_if;
  import seg7_pkg::*;

  logic                  load;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dp;
  logic [DIGITS-1:0]     en_mask;
  logic [2:0]            pos;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;
  logic                  dp_n;
  logic                  frame_done;
  logic                  load_ack;

  modport master (
    output load, data, dp, en_mask,
    input  pos, an, seg, dp_n, frame_done, load_ack
  );

  modport slave (
    input  load, data, dp, en_mask,
    output pos, an, seg, dp_n, frame_done, load_ack
  );

endinterface

// File: rtl/seg7_scan_ctrl_hex_to_seg7.sv
// Combinational nibble-to-glyph encoder, active-low {g,f,e,d,c,b,a}.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_GLYPH[nib];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scan controller; new values are
// staged in a pending pair and only become active when the scan wraps.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int DW = cnt_width(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0]       div_cnt;
  logic [2:0]          pos;
  logic [4*DIGITS-1:0] act_data;
  logic [4*DIGITS-1:0] pend_data;
  logic [DIGITS-1:0]   act_dp;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend_valid;
  logic                tick;
  logic                wrap;
  logic                digit_en;
  logic [3:0]          nib;
  logic [6:0]          glyph;

  assign tick     = (div_cnt == DIV_LAST);
  assign wrap     = tick && (pos == 3'd7);
  assign digit_en = bus.en_mask[pos];
  assign nib      = act_data[{pos, 2'b00} +: 4];
  assign bus.pos  = pos;

  hex_to_seg7 u_glyph (
    .nib (nib),
    .seg (glyph)
  );

  // A load landing exactly on the wrap bypasses the pending pair entirely
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt        <= '0;
      pos            <= '0;
      act_data       <= '0;
      act_dp         <= '0;
      pend_data      <= '0;
      pend_dp        <= '0;
      pend_valid     <= 1'b0;
      bus.an         <= '1;
      bus.seg        <= SEG_BLANK;
      bus.dp_n       <= 1'b1;
      bus.frame_done <= 1'b0;
      bus.load_ack   <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (tick) begin
        pos <= pos + 3'd1;
      end

      if (wrap) begin
        if (bus.load) begin
          act_data <= bus.data;
          act_dp   <= bus.dp;
        end else if (pend_valid) begin
          act_data <= pend_data;
          act_dp   <= pend_dp;
        end
        pend_valid   <= 1'b0;
        bus.load_ack <= bus.load | pend_valid;
      end else begin
        bus.load_ack <= 1'b0;
        if (bus.load) begin
          pend_data  <= bus.data;
          pend_dp    <= bus.dp;
          pend_valid <= 1'b1;
        end
      end

      bus.frame_done <= wrap;
      bus.an         <= digit_en ? ~(8'b1 << pos) : '1;
      bus.seg        <= digit_en ? glyph : SEG_BLANK;
      bus.dp_n       <= digit_en ? ~act_dp[pos] : 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench: a cycle model predicts the CLK_DIV=4 instance into a
// scoreboard queue, plus directed spot checks and a CLK_DIV=1 instance.
module tb_seg7_scan_ctrl;

  localparam int DIV4 = 4;
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [2:0] pos;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       fd;
    logic       ack;
  } exp_t;

  logic clk;
  logic rst;
  logic rst1;
  int   vectors;
  int   miscompares;
  exp_t sb_q [$];

  int          m_cycles;
  logic [31:0] m_act_data;
  logic [31:0] m_pend_data;
  logic [7:0]  m_act_dp;
  logic [7:0]  m_pend_dp;
  logic        m_pend_valid;

  seg7_scan_ctrl_if bus4 ();
  seg7_scan_ctrl_if bus1 ();

  seg7_scan_ctrl #(.CLK_DIV(DIV4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  seg7_scan_ctrl #(.CLK_DIV(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: digit position is derived from cycles since reset
  always @(posedge clk) begin : model
    exp_t       e;
    int         cp;
    logic       tk;
    logic       wr;
    logic       en;
    logic [3:0] nb;
    e = '0;
    if (rst) begin
      e.pos  = 3'd0;
      e.an   = 8'hFF;
      e.seg  = 7'h7F;
      e.dp_n = 1'b1;
      m_cycles     <= 0;
      m_act_data   <= '0;
      m_act_dp     <= '0;
      m_pend_valid <= 1'b0;
    end else begin
      cp = (m_cycles / DIV4) % 8;
      tk = (m_cycles % DIV4) == DIV4 - 1;
      wr = tk && (cp == 7);
      en = bus4.en_mask[cp];
      nb = m_act_data[4*cp +: 4];
      e.an = 8'hFF;
      if (en) e.an[cp] = 1'b0;
      e.seg  = en ? GLYPH[nb] : 7'h7F;
      e.dp_n = en ? ~m_act_dp[cp] : 1'b1;
      e.fd   = wr;
      e.ack  = wr && (bus4.load || m_pend_valid);
      e.pos  = 3'(((m_cycles + 1) / DIV4) % 8);
      if (wr) begin
        if (bus4.load) begin
          m_act_data <= bus4.data;
          m_act_dp   <= bus4.dp;
        end else if (m_pend_valid) begin
          m_act_data <= m_pend_data;
          m_act_dp   <= m_pend_dp;
        end
        m_pend_valid <= 1'b0;
      end else if (bus4.load) begin
        m_pend_data  <= bus4.data;
        m_pend_dp    <= bus4.dp;
        m_pend_valid <= 1'b1;
      end
      m_cycles <= m_cycles + 1;
    end
    sb_q.push_back(e);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("pos", 32'(bus4.pos), 32'(e.pos));
      check("an", 32'(bus4.an), 32'(e.an));
      check("seg", 32'(bus4.seg), 32'(e.seg));
      check("dp_n", 32'(bus4.dp_n), 32'(e.dp_n));
      check("frame_done", 32'(bus4.frame_done), 32'(e.fd));
      check("load_ack", 32'(bus4.load_ack), 32'(e.ack));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic [7:0] p);
    bus4.load = 1'b1;
    bus4.data = d;
    bus4.dp   = p;
    cycle();
    bus4.load = 1'b0;
  endtask

  task automatic waitPos(input logic [2:0] p);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      cycle();
      if (bus4.pos === p) found = 1;
    end
    check("wait_pos", 32'(found), 32'd1);
  endtask

  task automatic waitFrame(output int acks);
    bit found = 0;
    acks = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      cycle();
      if (bus4.load_ack === 1'b1) acks++;
      if (bus4.frame_done === 1'b1) found = 1;
    end
    check("wait_frame", 32'(found), 32'd1);
  endtask

  initial begin
    int acks;
    int blanks;
    int dpon;
    int fds;
    vectors     = 0;
    miscompares = 0;
    rst  = 1'b1;
    rst1 = 1'b1;
    bus4.load = 1'b0; bus4.data = '0; bus4.dp = '0; bus4.en_mask = 8'hFF;
    bus1.load = 1'b0; bus1.data = '0; bus1.dp = '0; bus1.en_mask = 8'hFF;

    // Reset held for three cycles, then digit 0 shows 0
    repeat (3) cycle();
    check("rst_an", 32'(bus4.an), 32'h00FF);
    check("rst_seg", 32'(bus4.seg), 32'h007F);
    check("rst_dp_n", 32'(bus4.dp_n), 32'd1);
    rst = 1'b0;
    cycle();
    check("rel_an", 32'(bus4.an), 32'h00FE);
    check("rel_seg", 32'(bus4.seg), 32'h0040);

    // Scan order with 0x76543210
    applyStimulus(32'h76543210, 8'h00);
    waitFrame(acks);
    check("scan_ack", 32'(acks), 32'd1);
    fds = 0;
    for (int i = 0; i < 64; i++) begin
      cycle();
      if (bus4.frame_done === 1'b1) fds++;
    end
    check("scan_fd_count", 32'(fds), 32'd2);

    // Frame-boundary commit of a load issued at pos 3
    waitPos(3'd3);
    applyStimulus(32'h89ABCDEF, 8'h00);
    waitFrame(acks);
    check("commit_ack", 32'(bus4.load_ack), 32'd1);
    cycle();
    check("commit_an", 32'(bus4.an), 32'h00FE);
    check("commit_seg", 32'(bus4.seg), 32'h000E);

    // Last load in a frame wins, single acknowledge
    waitPos(3'd1);
    applyStimulus(32'h11111111, 8'h00);
    repeat (3) cycle();
    applyStimulus(32'h22222222, 8'h00);
    waitFrame(acks);
    check("last_wins_acks", 32'(acks), 32'd1);
    cycle();
    check("last_wins_seg", 32'(bus4.seg), 32'h0024);

    // Load landing in the wrap cycle itself
    repeat (30) cycle();
    applyStimulus(32'h33333333, 8'h00);
    check("wrapload_fd", 32'(bus4.frame_done), 32'd1);
    check("wrapload_ack", 32'(bus4.load_ack), 32'd1);
    cycle();
    check("wrapload_seg", 32'(bus4.seg), 32'h0030);

    // Masking and decimal point
    bus4.en_mask = 8'h0F;
    applyStimulus(32'h76543210, 8'h01);
    waitFrame(acks);
    blanks = 0; dpon = 0; fds = 0;
    for (int i = 0; i < 32; i++) begin
      cycle();
      if (bus4.an === 8'hFF) blanks++;
      if (bus4.dp_n === 1'b0) dpon++;
      if (bus4.frame_done === 1'b1) fds++;
    end
    check("mask_blanks", 32'(blanks), 32'd16);
    check("mask_dp", 32'(dpon), 32'd4);
    check("mask_fd", 32'(fds), 32'd1);

    // Mid-frame reset discards a pending value
    bus4.en_mask = 8'hFF;
    waitPos(3'd2);
    applyStimulus(32'hAAAAAAAA, 8'hFF);
    cycle();
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    check("mrst_an", 32'(bus4.an), 32'h00FE);
    check("mrst_seg", 32'(bus4.seg), 32'h0040);
    check("mrst_dp_n", 32'(bus4.dp_n), 32'd1);
    waitFrame(acks);
    check("mrst_acks", 32'(acks), 32'd0);
    cycle();
    check("mrst_seg_after", 32'(bus4.seg), 32'h0040);

    // CLK_DIV = 1 instance: pos advances every cycle
    rst1 = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      cycle();
      check("div1_pos", 32'(bus1.pos), 32'(k % 8));
      check("div1_fd", 32'(bus1.frame_done), 32'((k % 8) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display. It holds a 32-bit hex value, steps a digit index through 0..7 at a programmable rate, and drives the active-low digit enables and segment lines for the current digit. New values are committed only at frame boundaries, so a partially updated value is never displayed. It sits between the CPU/debug datapath, which writes the value, and the display pins.

## Interface
- CLK_DIV, default 100000: clock cycles per digit slot; legal values are ≥ 1.
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- load  in  1  single-cycle request to write a new display value
- data  in  32  hex value to display; digit i shows data[4i+3:4i]
- dp  in  8  decimal points, one per digit, active-high; sampled together with data
- en_mask  in  8  digit enables, 1 = lit; used live, not latched
- pos  out  3  current digit index
- an  out  8  digit select, active-low, one-hot-low
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp_n  out  1  decimal point, active-low
- frame_done  out  1  one-cycle pulse when the scan wraps from digit 7 to digit 0
- load_ack  out  1  one-cycle pulse when a loaded value becomes active

## Operation
- Prescaler `div_cnt` counts 0..CLK_DIV-1 and then wraps. `tick` is high when div_cnt == CLK_DIV-1.
- On tick, pos advances by 1 modulo 8. Wrap is defined as tick while pos == 7.
- Registers are a pending pair (pend_data, pend_dp) with a pend_valid flag, and an active pair (act_data, act_dp).
- When load is high, data and dp are written into the pending pair and pend_valid is set. If several loads arrive within one frame, the last one wins.
- On wrap:
  - If load is high in that same cycle, data and dp go directly to the active pair.
  - Otherwise, if pend_valid is set, the pending pair is copied to the active pair.
  - In both cases pend_valid is cleared and load_ack pulses on the next cycle. With no commit, there is no load_ack.
- Display encoding:
  - nib = act_data[4*pos +: 4], encoded as standard hex glyphs.
  - Values: 0 = 1000000, 1 = 1111001, 8 = 0000000, A = 0001000, F = 0001110.
- Outputs, registered, computed from the current pos:
  - an = ~(8'b1 << pos) if en_mask[pos] is set, else 8'hFF.
  - seg = the glyph for nib when the digit is enabled, else 7'h7F.
  - dp_n = ~act_dp[pos] when the digit is enabled, else 1.
- frame_done is registered from wrap.

## Timing
- Reset values:
  - pos = 0, div_cnt = 0, act_data = 0, act_dp = 0, pend_valid = 0.
  - an = 8'hFF, seg = 7'h7F, dp_n = 1, frame_done = 0, load_ack = 0.
- Latency:
  - an, seg and dp_n reflect a new pos one cycle after pos changes.
  - load_ack and frame_done assert one cycle after the wrap cycle, for exactly one cycle.
  - A load becomes visible between 1 and 8·CLK_DIV+1 cycles after it is issued.
- CLK_DIV == 1: tick is permanently high, pos advances every cycle, and frame_done pulses every 8 cycles.
- Reset has priority over everything. A load in the same cycle as rst is discarded. Reset mid-frame discards any pending value.
- en_mask changes take effect on the next registered output update. They never disturb pos or commit timing.

## Structure
- Package `seg7_pkg`:
  - DIGITS = 8
  - SEG_BLANK = 7'h7F
  - the 16-entry hex glyph constant table
  - $clog2-based width function for div_cnt
- Sub-module `hex_to_seg7`: combinational 4-bit to 7-bit active-low glyph encoder. It is instantiated once on nib.
- The top level contains the prescaler, scan counter, pending/active registers and output registers.

## Test plan
- **Reset:** with CLK_DIV = 4, hold rst for 3 cycles, then release. → While in reset, an = FF, seg = 7F and dp_n = 1. In the cycle after release, an = FE and seg = 1000000 (digit 0 shows 0).
- **Scan order:** CLK_DIV = 4, en_mask = FF, data = 0x76543210. → pos steps 0..7 every 4 cycles. an walks FE, FD, …, 7F. seg matches glyphs 0..7. frame_done pulses once every 32 cycles.
- **Frame-boundary commit:** load 0x89ABCDEF while pos = 3. → The display keeps its old value through pos = 7. act_data changes only at wrap. load_ack pulses together with frame_done. Digit 0 then shows F (0001110).
- **Last load wins and load at wrap:** load 0x11111111 and then 0x22222222 in the same frame. → Only 0x22222222 is displayed, with a single load_ack. A load of 0x33333333 in the wrap cycle itself is active from digit 0 of the next frame.
- **Masking and dp:** en_mask = 0x0F, dp = 0x01. → Digits 4–7 give an = FF and seg = 7F. dp_n = 0 only on digit 0. The pos cadence is unchanged.
- **Mid-frame reset and CLK_DIV = 1:** assert rst with a load pending. → After reset there is no load_ack and act_data = 0. With CLK_DIV = 1, pos increments every cycle.
